// File: rtl/font_5x7_pkg.sv
// Font constants and the 5x7 glyph table for codes 0x20..0x7E.
// Glyphs are stored column-major, five bytes per glyph; bit 0 is the top
// row, and bit 7 is always clear so the bottom row stays blank.
package font_5x7_pkg;

  localparam int GLYPH_W = 5;
  localparam int CELL_W  = 6;
  localparam int GLYPH_H = 7;

  localparam logic [7:0] FIRST_CHAR = 8'h20;
  localparam logic [7:0] LAST_CHAR  = 8'h7E;
  localparam logic [7:0] BLOCK_CHAR = 8'h7F;

  localparam int GLYPH_COUNT = 95;
  localparam int ROM_DEPTH   = GLYPH_COUNT * GLYPH_W;

  localparam logic [7:0] GLYPH_ROM [0:ROM_DEPTH-1] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00,  // 0x20 ' '
    8'h00, 8'h00, 8'h5F, 8'h00, 8'h00,  // 0x21 '!'
    8'h00, 8'h07, 8'h00, 8'h07, 8'h00,  // 0x22 '"'
    8'h14, 8'h7F, 8'h14, 8'h7F, 8'h14,  // 0x23 '#'
    8'h24, 8'h2A, 8'h7F, 8'h2A, 8'h12,  // 0x24 '$'
    8'h23, 8'h13, 8'h08, 8'h64, 8'h62,  // 0x25 '%'
    8'h36, 8'h49, 8'h55, 8'h22, 8'h50,  // 0x26 '&'
    8'h00, 8'h05, 8'h03, 8'h00, 8'h00,  // 0x27 '''
    8'h00, 8'h1C, 8'h22, 8'h41, 8'h00,  // 0x28 '('
    8'h00, 8'h41, 8'h22, 8'h1C, 8'h00,  // 0x29 ')'
    8'h14, 8'h08, 8'h3E, 8'h08, 8'h14,  // 0x2A '*'
    8'h08, 8'h08, 8'h3E, 8'h08, 8'h08,  // 0x2B '+'
    8'h00, 8'h50, 8'h30, 8'h00, 8'h00,  // 0x2C ','
    8'h08, 8'h08, 8'h08, 8'h08, 8'h08,  // 0x2D '-'
    8'h00, 8'h60, 8'h60, 8'h00, 8'h00,  // 0x2E '.'
    8'h20, 8'h10, 8'h08, 8'h04, 8'h02,  // 0x2F '/'
    8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E,  // 0x30 '0'
    8'h00, 8'h42, 8'h7F, 8'h40, 8'h00,  // 0x31 '1'
    8'h42, 8'h61, 8'h51, 8'h49, 8'h46,  // 0x32 '2'
    8'h21, 8'h41, 8'h45, 8'h4B, 8'h31,  // 0x33 '3'
    8'h18, 8'h14, 8'h12, 8'h7F, 8'h10,  // 0x34 '4'
    8'h27, 8'h45, 8'h45, 8'h45, 8'h39,  // 0x35 '5'
    8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30,  // 0x36 '6'
    8'h01, 8'h71, 8'h09, 8'h05, 8'h03,  // 0x37 '7'
    8'h36, 8'h49, 8'h49, 8'h49, 8'h36,  // 0x38 '8'
    8'h06, 8'h49, 8'h49, 8'h29, 8'h1E,  // 0x39 '9'
    8'h00, 8'h36, 8'h36, 8'h00, 8'h00,  // 0x3A ':'
    8'h00, 8'h56, 8'h36, 8'h00, 8'h00,  // 0x3B ';'
    8'h08, 8'h14, 8'h22, 8'h41, 8'h00,  // 0x3C '<'
    8'h14, 8'h14, 8'h14, 8'h14, 8'h14,  // 0x3D '='
    8'h00, 8'h41, 8'h22, 8'h14, 8'h08,  // 0x3E '>'
    8'h02, 8'h01, 8'h51, 8'h09, 8'h06,  // 0x3F '?'
    8'h32, 8'h49, 8'h79, 8'h41, 8'h3E,  // 0x40 '@'
    8'h7E, 8'h11, 8'h11, 8'h11, 8'h7E,  // 0x41 'A'
    8'h7F, 8'h49, 8'h49, 8'h49, 8'h36,  // 0x42 'B'
    8'h3E, 8'h41, 8'h41, 8'h41, 8'h22,  // 0x43 'C'
    8'h7F, 8'h41, 8'h41, 8'h22, 8'h1C,  // 0x44 'D'
    8'h7F, 8'h49, 8'h49, 8'h49, 8'h41,  // 0x45 'E'
    8'h7F, 8'h09, 8'h09, 8'h09, 8'h01,  // 0x46 'F'
    8'h3E, 8'h41, 8'h49, 8'h49, 8'h7A,  // 0x47 'G'
    8'h7F, 8'h08, 8'h08, 8'h08, 8'h7F,  // 0x48 'H'
    8'h00, 8'h41, 8'h7F, 8'h41, 8'h00,  // 0x49 'I'
    8'h20, 8'h40, 8'h41, 8'h3F, 8'h01,  // 0x4A 'J'
    8'h7F, 8'h08, 8'h14, 8'h22, 8'h41,  // 0x4B 'K'
    8'h7F, 8'h40, 8'h40, 8'h40, 8'h40,  // 0x4C 'L'
    8'h7F, 8'h02, 8'h0C, 8'h02, 8'h7F,  // 0x4D 'M'
    8'h7F, 8'h04, 8'h08, 8'h10, 8'h7F,  // 0x4E 'N'
    8'h3E, 8'h41, 8'h41, 8'h41, 8'h3E,  // 0x4F 'O'
    8'h7F, 8'h09, 8'h09, 8'h09, 8'h06,  // 0x50 'P'
    8'h3E, 8'h41, 8'h51, 8'h21, 8'h5E,  // 0x51 'Q'
    8'h7F, 8'h09, 8'h19, 8'h29, 8'h46,  // 0x52 'R'
    8'h46, 8'h49, 8'h49, 8'h49, 8'h31,  // 0x53 'S'
    8'h01, 8'h01, 8'h7F, 8'h01, 8'h01,  // 0x54 'T'
    8'h3F, 8'h40, 8'h40, 8'h40, 8'h3F,  // 0x55 'U'
    8'h1F, 8'h20, 8'h40, 8'h20, 8'h1F,  // 0x56 'V'
    8'h3F, 8'h40, 8'h38, 8'h40, 8'h3F,  // 0x57 'W'
    8'h63, 8'h14, 8'h08, 8'h14, 8'h63,  // 0x58 'X'
    8'h07, 8'h08, 8'h70, 8'h08, 8'h07,  // 0x59 'Y'
    8'h61, 8'h51, 8'h49, 8'h45, 8'h43,  // 0x5A 'Z'
    8'h00, 8'h7F, 8'h41, 8'h41, 8'h00,  // 0x5B '['
    8'h02, 8'h04, 8'h08, 8'h10, 8'h20,  // 0x5C '\'
    8'h00, 8'h41, 8'h41, 8'h7F, 8'h00,  // 0x5D ']'
    8'h04, 8'h02, 8'h01, 8'h02, 8'h04,  // 0x5E '^'
    8'h40, 8'h40, 8'h40, 8'h40, 8'h40,  // 0x5F '_'
    8'h00, 8'h01, 8'h02, 8'h04, 8'h00,  // 0x60 '`'
    8'h20, 8'h54, 8'h54, 8'h54, 8'h78,  // 0x61 'a'
    8'h7F, 8'h48, 8'h44, 8'h44, 8'h38,  // 0x62 'b'
    8'h38, 8'h44, 8'h44, 8'h44, 8'h20,  // 0x63 'c'
    8'h38, 8'h44, 8'h44, 8'h48, 8'h7F,  // 0x64 'd'
    8'h38, 8'h54, 8'h54, 8'h54, 8'h18,  // 0x65 'e'
    8'h08, 8'h7E, 8'h09, 8'h01, 8'h02,  // 0x66 'f'
    8'h0C, 8'h52, 8'h52, 8'h52, 8'h3E,  // 0x67 'g'
    8'h7F, 8'h08, 8'h04, 8'h04, 8'h78,  // 0x68 'h'
    8'h00, 8'h44, 8'h7D, 8'h40, 8'h00,  // 0x69 'i'
    8'h20, 8'h40, 8'h44, 8'h3D, 8'h00,  // 0x6A 'j'
    8'h7F, 8'h10, 8'h28, 8'h44, 8'h00,  // 0x6B 'k'
    8'h00, 8'h41, 8'h7F, 8'h40, 8'h00,  // 0x6C 'l'
    8'h7C, 8'h04, 8'h18, 8'h04, 8'h78,  // 0x6D 'm'
    8'h7C, 8'h08, 8'h04, 8'h04, 8'h78,  // 0x6E 'n'
    8'h38, 8'h44, 8'h44, 8'h44, 8'h38,  // 0x6F 'o'
    8'h7C, 8'h14, 8'h14, 8'h14, 8'h08,  // 0x70 'p'
    8'h08, 8'h14, 8'h14, 8'h18, 8'h7C,  // 0x71 'q'
    8'h7C, 8'h08, 8'h04, 8'h04, 8'h08,  // 0x72 'r'
    8'h48, 8'h54, 8'h54, 8'h54, 8'h20,  // 0x73 's'
    8'h04, 8'h3F, 8'h44, 8'h40, 8'h20,  // 0x74 't'
    8'h3C, 8'h40, 8'h40, 8'h20, 8'h7C,  // 0x75 'u'
    8'h1C, 8'h20, 8'h40, 8'h20, 8'h1C,  // 0x76 'v'
    8'h3C, 8'h40, 8'h30, 8'h40, 8'h3C,  // 0x77 'w'
    8'h44, 8'h28, 8'h10, 8'h28, 8'h44,  // 0x78 'x'
    8'h0C, 8'h50, 8'h50, 8'h50, 8'h3C,  // 0x79 'y'
    8'h44, 8'h64, 8'h54, 8'h4C, 8'h44,  // 0x7A 'z'
    8'h00, 8'h08, 8'h36, 8'h41, 8'h00,  // 0x7B '{'
    8'h00, 8'h00, 8'h7F, 8'h00, 8'h00,  // 0x7C '|'
    8'h00, 8'h41, 8'h36, 8'h08, 8'h00,  // 0x7D '}'
    8'h10, 8'h08, 8'h08, 8'h10, 8'h08   // 0x7E '~'
  };

  // Table address of a printable glyph column: (code - FIRST_CHAR) * 5 + column.
  // The multiply by five is written as shift-and-add to keep widths explicit.
  function automatic logic [8:0] glyph_index(input logic [7:0] code, input logic [2:0] column);
    logic [8:0] offset;
    offset = {1'b0, code - FIRST_CHAR};
    return (offset << 2) + offset + {6'd0, column};
  endfunction

endpackage

// File: rtl/font_5x7_rom.sv
// Combinational glyph lookup: returns one column byte for a character code
// and cell column. Control codes, spacer/out-of-cell columns give 0x00; the
// block code gives a solid 0x7F column.
module font_5x7_rom
  import font_5x7_pkg::*;
(
  input  logic [6:0] character,
  input  logic [2:0] col,
  output logic [7:0] data
);

  logic [7:0] code;
  logic [8:0] index;

  assign code = {1'b0, character};

  // Range-checked table read; anything outside the printable range or the
  // 5-column glyph area is blank.
  always_comb begin
    data  = 8'h00;
    index = 9'd0;
    if (col < 3'(GLYPH_W)) begin
      if (code == BLOCK_CHAR) begin
        data = 8'h7F;
      end else if ((code >= FIRST_CHAR) && (code <= LAST_CHAR)) begin
        index = glyph_index(code, col);
        data  = GLYPH_ROM[index];
      end
    end
  end

endmodule

// File: rtl/font_5x7_glyph.sv
// Character-generator ROM for the LCD text path: character code + cell
// column in, one registered 8-pixel column byte out.
// Build option FONT_5X7_OUTREG_EN adds a second output register stage
// (2-cycle latency); otherwise the lookup has 1-cycle latency.
// Reset is asynchronous, active-low, and clears every stage to 0x00.
module font_5x7_glyph
  import font_5x7_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] character,
  input  logic [2:0] col,
  output logic [7:0] pixels
);

  logic [7:0] rom_data;
  logic [7:0] read_reg;

  font_5x7_rom u_rom (
    .character (character),
    .col       (col),
    .data      (rom_data)
  );

  // Registered ROM read; cleared immediately when reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_reg <= 8'h00;
    end else begin
      read_reg <= rom_data;
    end
  end

`ifdef FONT_5X7_OUTREG_EN
  logic [7:0] out_reg;

  // Extra output stage to ease timing into the LCD driver.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg <= 8'h00;
    end else begin
      out_reg <= read_reg;
    end
  end

  assign pixels = out_reg;
`else
  assign pixels = read_reg;
`endif

endmodule

// File: tb/tb_font_5x7_glyph.sv
// Directed bench for font_5x7_glyph. Latency follows FONT_5X7_OUTREG_EN.
module tb_font_5x7_glyph;

`ifdef FONT_5X7_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] character = 7'h00;
  logic [2:0] col = 3'd0;
  logic [7:0] pixels;

  int checks = 0;
  int errors = 0;

  font_5x7_glyph dut (
    .clk       (clk),
    .reset     (reset),
    .character (character),
    .col       (col),
    .pixels    (pixels)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    character = 7'h41;
    col = 3'd0;
    #1;
    checks++;
    if (pixels !== 8'h00) begin
      errors++;
      $display("FAIL reset_async_noclk: got %02h expected 00", pixels);
    end else $display("ok reset_async_noclk pixels=%02h", pixels);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pixels !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %02h expected 00", i, pixels);
      end else $display("ok reset_hold cyc %0d pixels=%02h", i, pixels);
    end
    reset = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      checks++;
      if (i < LAT) begin
        if (pixels !== 8'h00) begin
          errors++;
          $display("FAIL reset_release edge %0d: got %02h expected 00", i, pixels);
        end else $display("ok reset_release edge %0d pixels=%02h", i, pixels);
      end else begin
        if (pixels !== 8'h7E) begin
          errors++;
          $display("FAIL reset_release edge %0d: got %02h expected 7E", i, pixels);
        end else $display("ok reset_release edge %0d pixels=%02h", i, pixels);
      end
    end
  endtask

  task automatic test_glyph_sweep();
    logic [7:0] exp_v [6] = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h7E, 8'h00};
    for (int i = 0; i < 6 + LAT - 1; i++) begin
      if (i < 6) begin
        character = 7'h41;
        col = 3'(i);
      end
      @(posedge clk); #1;
      if (i - LAT + 1 >= 0) begin
        checks++;
        if (pixels !== exp_v[i-LAT+1]) begin
          errors++;
          $display("FAIL glyph_sweep 41 col %0d: got %02h expected %02h", i - LAT + 1, pixels, exp_v[i-LAT+1]);
        end else $display("ok glyph_sweep 41 col %0d pixels=%02h", i - LAT + 1, pixels);
      end
    end
  endtask

  task automatic test_spacer();
    logic [2:0] col_v [4] = '{3'd5, 3'd6, 3'd7, 3'd0};
    logic [7:0] exp_v [4] = '{8'h00, 8'h00, 8'h00, 8'h7F};
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      if (i < 4) begin
        character = 7'h48;
        col = col_v[i];
      end
      @(posedge clk); #1;
      if (i - LAT + 1 >= 0) begin
        checks++;
        if (pixels !== exp_v[i-LAT+1]) begin
          errors++;
          $display("FAIL spacer 48 col %0d: got %02h expected %02h", col_v[i-LAT+1], pixels, exp_v[i-LAT+1]);
        end else $display("ok spacer 48 col %0d pixels=%02h", col_v[i-LAT+1], pixels);
      end
    end
  endtask

  task automatic test_control_block();
    logic [6:0] ch_v  [16];
    logic [7:0] exp_v [16];
    for (int i = 0; i < 8; i++) begin
      ch_v[i] = 7'h05;
      exp_v[i] = 8'h00;
      ch_v[8+i] = 7'h7F;
      exp_v[8+i] = (i < 5) ? 8'h7F : 8'h00;
    end
    for (int i = 0; i < 16 + LAT - 1; i++) begin
      if (i < 16) begin
        character = ch_v[i];
        col = 3'(i % 8);
      end
      @(posedge clk); #1;
      if (i - LAT + 1 >= 0) begin
        checks++;
        if (pixels !== exp_v[i-LAT+1]) begin
          errors++;
          $display("FAIL control_block %02h col %0d: got %02h expected %02h",
                   ch_v[i-LAT+1], (i - LAT + 1) % 8, pixels, exp_v[i-LAT+1]);
        end else $display("ok control_block %02h col %0d pixels=%02h",
                          ch_v[i-LAT+1], (i - LAT + 1) % 8, pixels);
      end
    end
  endtask

  // Every code and column: bit 7 clear; control codes and columns 5..7 blank.
  task automatic test_bit7_sweep();
    int bad = 0;
    for (int c = 0; c < 128; c++) begin
      for (int k = 0; k < 8; k++) begin
        character = 7'(c);
        col = 3'(k);
        repeat (LAT) @(posedge clk);
        #1;
        checks++;
        if (pixels[7] !== 1'b0) begin
          errors++;
          bad++;
          $display("FAIL bit7 code %02h col %0d: got %02h expected bit7=0", c, k, pixels);
        end
        if (c < 32 || k >= 5) begin
          checks++;
          if (pixels !== 8'h00) begin
            errors++;
            bad++;
            $display("FAIL blank code %02h col %0d: got %02h expected 00", c, k, pixels);
          end
        end
      end
    end
    $display("ok bit7_sweep done, %0d bad lookups", bad);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ch_v  [14] = '{7'h21, 7'h21, 7'h21, 7'h30, 7'h30, 7'h30, 7'h30, 7'h30,
                               7'h20, 7'h48, 7'h41, 7'h7F, 7'h48, 7'h21};
    logic [2:0] col_v [14] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                               3'd2, 3'd1, 3'd4, 3'd3, 3'd4, 3'd2};
    logic [7:0] exp_v [14] = '{8'h00, 8'h5F, 8'h00, 8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E,
                               8'h00, 8'h08, 8'h7E, 8'h7F, 8'h7F, 8'h5F};
    for (int i = 0; i < 14 + LAT - 1; i++) begin
      if (i < 14) begin
        character = ch_v[i];
        col = col_v[i];
      end
      @(posedge clk); #1;
      if (i - LAT + 1 >= 0) begin
        checks++;
        if (pixels !== exp_v[i-LAT+1]) begin
          errors++;
          $display("FAIL back_to_back %02h col %0d: got %02h expected %02h",
                   ch_v[i-LAT+1], col_v[i-LAT+1], pixels, exp_v[i-LAT+1]);
        end else $display("ok back_to_back %02h col %0d pixels=%02h",
                          ch_v[i-LAT+1], col_v[i-LAT+1], pixels);
      end
    end
  endtask

  task automatic test_async_reset();
    character = 7'h30;
    for (int k = 0; k <= LAT; k++) begin
      col = 3'(k);
      @(posedge clk); #1;
    end
    checks++;
    if (pixels !== 8'h51) begin
      errors++;
      $display("FAIL midstream_before_reset: got %02h expected 51", pixels);
    end else $display("ok midstream_before_reset pixels=%02h", pixels);
    col = 3'(LAT + 1);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (pixels !== 8'h00) begin
      errors++;
      $display("FAIL midstream_reset_immediate: got %02h expected 00", pixels);
    end else $display("ok midstream_reset_immediate pixels=%02h", pixels);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pixels !== 8'h00) begin
        errors++;
        $display("FAIL midstream_reset_hold cyc %0d: got %02h expected 00", i, pixels);
      end else $display("ok midstream_reset_hold cyc %0d pixels=%02h", i, pixels);
    end
    reset = 1'b1;
    col = 3'd4;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      checks++;
      if (i < LAT) begin
        if (pixels !== 8'h00) begin
          errors++;
          $display("FAIL midstream_refill edge %0d: got %02h expected 00", i, pixels);
        end else $display("ok midstream_refill edge %0d pixels=%02h", i, pixels);
      end else begin
        if (pixels !== 8'h3E) begin
          errors++;
          $display("FAIL midstream_refill edge %0d: got %02h expected 3E", i, pixels);
        end else $display("ok midstream_refill edge %0d pixels=%02h", i, pixels);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_glyph_sweep();
    test_spacer();
    test_control_block();
    test_back_to_back();
    test_bit7_sweep();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
